// File: rtl/mine_placer_if.sv
`default_nettype none
// ============================================================================
// Module      : mine_placer_if
// Description : Bundle between the game controller / LFSR side and the mine
//               placer. The master drives start, the first-click cell and the
//               LFSR candidate stream; the slave (mine_placer) returns run
//               status, the placed-mine count and the flat mine bitmap.
//   start     master->slave  begin a run (level, sampled while idle)
//   safe_idx  master->slave  cell that must stay mine-free
//   random    master->slave  candidate cell index, new value every clock
//   busy      slave->master  run in progress
//   done      slave->master  one-cycle end-of-run pulse
//   fail      slave->master  run ended with the try budget exhausted
//   placed    slave->master  mines placed so far
//   mine_map  slave->master  bit i set -> mine at cell i (row*COLS+col)
// Revision    : 1.0 - initial release
// ============================================================================
interface mine_placer_if #(
  parameter int IDX_W = 6,
  parameter int CELLS = 64
);
  logic             start;
  logic [IDX_W-1:0] safe_idx;
  logic [IDX_W-1:0] random;
  logic             busy;
  logic             done;
  logic             fail;
  logic [IDX_W:0]   placed;
  logic [CELLS-1:0] mine_map;

  modport master (
    output start, safe_idx, random,
    input  busy, done, fail, placed, mine_map
  );

  modport slave (
    input  start, safe_idx, random,
    output busy, done, fail, placed, mine_map
  );
endinterface
`default_nettype wire

// File: rtl/mine_placer.sv
`default_nettype none
// ============================================================================
// Module      : mine_placer
// Description : Places exactly MINES mines on a ROWS x COLS board using one
//               LFSR candidate per clock. Candidates that are off the board,
//               equal to the latched first-click cell, or already mined are
//               rejected. A run ends with done; fail marks that the try
//               budget ran out before the map was complete.
//   clk   : clock
//   rst   : asynchronous active-high reset
//   bus   : mine_placer_if slave modport (start, safe_idx, random in;
//           busy, done, fail, placed, mine_map out)
// Revision    : 1.0 - initial release
// ============================================================================
module mine_placer #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int MINES     = 10,
  parameter int IDX_W     = 6,
  parameter int MAX_TRIES = 1024
) (
  input  wire logic        clk,
  input  wire logic        rst,
  mine_placer_if.slave     bus
);

  localparam int c_CELLS = ROWS * COLS;
  localparam int c_TRY_W = $clog2(MAX_TRIES + 1);

  localparam logic [IDX_W:0]   c_CELLS_V = (IDX_W + 1)'(c_CELLS);
  localparam logic [IDX_W:0]   c_MINES_V = (IDX_W + 1)'(MINES);
  localparam logic [c_TRY_W-1:0] c_TRIES_V = c_TRY_W'(MAX_TRIES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [IDX_W-1:0]   r_safe;
  logic [c_TRY_W-1:0] r_tries;
  logic [IDX_W:0]     r_placed;
  logic [c_CELLS-1:0] r_map;
  logic               r_fail;

  logic               w_in_range;
  logic               w_is_safe;
  logic               w_occupied;
  logic               w_accept;
  logic [IDX_W:0]     w_placed_inc;
  logic [c_TRY_W-1:0] w_tries_inc;
  logic               w_complete;
  logic               w_exhausted;

  // Candidate qualification. The occupancy lookup is gated by the range
  // check so indices beyond the board never address the bitmap.
  assign w_in_range   = {1'b0, bus.random} < c_CELLS_V;
  assign w_is_safe    = bus.random == r_safe;
  assign w_occupied   = w_in_range && r_map[bus.random];
  assign w_accept     = w_in_range && !w_is_safe && !w_occupied;
  assign w_placed_inc = r_placed + 1'b1;
  assign w_tries_inc  = r_tries + 1'b1;
  assign w_complete   = w_accept && (w_placed_inc == c_MINES_V);
  assign w_exhausted  = w_tries_inc == c_TRIES_V;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_state_next = S_CLEAR;
      S_CLEAR:  w_state_next = S_SAMPLE;
      S_SAMPLE: if (w_complete || w_exhausted) w_state_next = S_DONE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_safe   <= '0;
      r_tries  <= '0;
      r_placed <= '0;
      r_map    <= '0;
      r_fail   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) r_safe <= bus.safe_idx;
        end
        S_CLEAR: begin
          r_tries  <= '0;
          r_placed <= '0;
          r_map    <= '0;
          r_fail   <= 1'b0;
        end
        S_SAMPLE: begin
          r_tries <= w_tries_inc;
          if (w_accept) begin
            r_map[bus.random] <= 1'b1;
            r_placed          <= w_placed_inc;
          end
          // A completing accept on the final try wins over the abort.
          if (w_exhausted && !w_complete) r_fail <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (r_state == S_CLEAR) || (r_state == S_SAMPLE);
  assign bus.done     = r_state == S_DONE;
  assign bus.fail     = r_fail;
  assign bus.placed   = r_placed;
  assign bus.mine_map = r_map;

endmodule
`default_nettype wire

// File: tb/tb_mine_placer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mine_placer
// Description : Self-checking bench for mine_placer on a 5x5 board with a
//               small try budget so both completion and abort occur. Each run
//               feeds a candidate list; a reference model derives the final
//               map, count, fail flag and run length from the placement rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mine_placer;

  localparam int ROWS      = 5;
  localparam int COLS      = 5;
  localparam int MINES     = 6;
  localparam int IDX_W     = 5;
  localparam int MAX_TRIES = 12;
  localparam int CELLS     = ROWS * COLS;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   stim [MAX_TRIES];

  mine_placer_if #(.IDX_W(IDX_W), .CELLS(CELLS)) bus ();

  mine_placer #(
    .ROWS(ROWS), .COLS(COLS), .MINES(MINES),
    .IDX_W(IDX_W), .MAX_TRIES(MAX_TRIES)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: walk the candidate list applying the placement rules.
  task automatic model(input int s, output logic [CELLS-1:0] map,
                       output int placed, output bit fl, output int t);
    map = '0; placed = 0; fl = 1'b0; t = 0;
    for (int j = 0; j < MAX_TRIES; j++) begin
      int r;
      r = stim[j];
      t = j + 1;
      if (r < CELLS && r != s && map[r] == 1'b0) begin
        map[r] = 1'b1;
        placed++;
        if (placed == MINES) return;
      end
      if (t == MAX_TRIES) begin
        fl = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_case(input int s, input bit hold, input bit wiggle);
    logic [CELLS-1:0] e_map;
    int e_placed, e_t;
    bit e_fail;
    model(s, e_map, e_placed, e_fail, e_t);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.safe_idx = IDX_W'(s);
    bus.random   = IDX_W'($urandom);
    @(posedge clk); #1;                       // edge k: start sampled
    check("busy_after_start", bus.busy, 1'b1);
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    if (wiggle) bus.safe_idx = IDX_W'($urandom);
    bus.random = IDX_W'($urandom);
    @(posedge clk); #1;                       // edge k+1: clear
    check("placed_cleared", bus.placed, 0);
    check("fail_cleared", bus.fail, 1'b0);
    for (int j = 0; j < e_t; j++) begin
      @(negedge clk);
      bus.random = IDX_W'(stim[j]);
      if (wiggle) bus.safe_idx = IDX_W'($urandom);
      @(posedge clk); #1;
      check("done_timing", bus.done, (j == e_t - 1));
      check("busy_timing", bus.busy, (j != e_t - 1));
    end
    check("mine_map", bus.mine_map, e_map);
    check("placed", bus.placed, e_placed);
    check("fail", bus.fail, e_fail);
    @(negedge clk);
    bus.random = IDX_W'($urandom);
    @(posedge clk); #1;                       // DONE -> IDLE, start ignored
    check("done_one_cycle", bus.done, 1'b0);
    check("idle_not_busy", bus.busy, 1'b0);
    check("map_held", bus.mine_map, e_map);
    check("fail_held", bus.fail, e_fail);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.safe_idx = '0;
    bus.random = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_fail", bus.fail, 1'b0);
    check("rst_placed", bus.placed, 0);
    check("rst_map", bus.mine_map, 0);
    @(negedge clk);
    rst = 1'b0;

    // Off-board, safe-cell and duplicate rejects mixed with accepts.
    stim = '{30, 25, 24, 0, 9, 3, 3, 5, 6, 7, 1, 2};
    run_case(9, 1'b0, 1'b0);

    // Candidate stuck on one cell: budget abort with a single mine.
    foreach (stim[i]) stim[i] = 7;
    run_case(9, 1'b0, 1'b0);

    // Map completes exactly on the last allowed try.
    stim = '{31, 31, 26, 4, 4, 4, 1, 2, 3, 5, 6, 0};
    run_case(4, 1'b0, 1'b0);

    // Out-of-range safe cell, start held high, safe_idx changing mid-run.
    stim = '{0, 1, 2, 3, 27, 4, 5, 6, 7, 8, 9, 10};
    run_case(27, 1'b1, 1'b1);
    run_case(2, 1'b1, 1'b1);

    // Reset asserted mid-run after one accept.
    stim = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
    @(negedge clk);
    bus.start = 1'b1;
    bus.safe_idx = 5'd20;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.random = 5'd3;
    @(posedge clk); #1;
    check("pre_rst_placed", bus.placed, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", bus.busy, 1'b0);
    check("async_rst_placed", bus.placed, 0);
    check("async_rst_map", bus.mine_map, 0);
    check("async_rst_done", bus.done, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      check("no_done_in_rst", bus.done, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    run_case(20, 1'b0, 1'b0);

    // Randomized runs.
    for (int n = 0; n < 25; n++) begin
      foreach (stim[i]) stim[i] = int'($urandom_range(0, 31));
      run_case(int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
